// File: rtl/data_mem_arbiter_if.sv
// Requester bus for the data-memory arbiter: port 0 is the CPU MEM stage, port 1 is DMA/debug.
// The master modport is the requester side; the slave modport is the arbiter side.
interface data_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   logic              req0;
   logic              we0;
   logic              lock0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic              lock1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   modport master (
      output req0, we0, lock0, addr0, wdata0,
      input  ack0, rdata0,
      output req1, we1, lock1, addr1, wdata1,
      input  ack1, rdata1
   );

   modport slave (
      input  req0, we0, lock0, addr0, wdata0,
      output ack0, rdata0,
      input  req1, we1, lock1, addr1, wdata1,
      output ack1, rdata1
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port sequencer in front of the single-port data memory.
// Each transaction takes IDLE -> ACCESS -> RESP; a locking owner may keep up to BURST_MAX grants.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   data_mem_arbiter_if.slave bus,
   output logic              mem_load,
   output logic              mem_store,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);
   localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              any_req;
   logic              own_req;
   logic              oth_req;
   logic              win;
   logic              lat_we;
   logic              lat_lock;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              last_grant;
   logic              owner_lock;
   logic [CNT_W-1:0]  burst_cnt;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              ack0_c;
   logic              ack1_c;

   assign any_req = bus.req0 | bus.req1;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (any_req) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Lock keeps the last owner while its burst budget lasts or nobody else is asking.
   always_comb begin
      own_req = last_grant ? bus.req1 : bus.req0;
      oth_req = last_grant ? bus.req0 : bus.req1;
      win     = ~bus.req0;
      if (owner_lock && own_req && ((burst_cnt < CNT_W'(BURST_MAX)) || !oth_req))
         win = last_grant;
      else if (bus.req0 && bus.req1)
         win = ~last_grant;
   end

   // Memory strobes and acks come from the state register only.
   always_comb begin
      mem_load  = 1'b0;
      mem_store = 1'b0;
      ack0_c    = 1'b0;
      ack1_c    = 1'b0;
      busy      = (state != S_IDLE);
      unique case (state)
         S_ACCESS: begin
            mem_store = lat_we;
            mem_load  = ~lat_we;
         end
         S_RESP: begin
            ack0_c = ~grant_id;
            ack1_c = grant_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         owner_lock <= 1'b0;
         burst_cnt  <= '0;
         lat_we     <= 1'b0;
         lat_lock   <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (any_req) begin
               grant_id  <= win;
               lat_we    <= win ? bus.we1    : bus.we0;
               lat_lock  <= win ? bus.lock1  : bus.lock0;
               lat_addr  <= win ? bus.addr1  : bus.addr0;
               lat_wdata <= win ? bus.wdata1 : bus.wdata0;
               if ((win == last_grant) && owner_lock) begin
                  if (burst_cnt < CNT_W'(BURST_MAX)) burst_cnt <= burst_cnt + CNT_W'(1);
               end else begin
                  burst_cnt <= CNT_W'(1);
               end
            end
            S_ACCESS: if (!lat_we) begin
               if (grant_id) rdata1_q <= mem_rdata;
               else          rdata0_q <= mem_rdata;
            end
            S_RESP: begin
               last_grant <= grant_id;
               owner_lock <= lat_lock;
               if (!lat_lock) burst_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign bus.ack0   = ack0_c;
   assign bus.ack1   = ack1_c;
   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;
endmodule
